// File: rtl/param_pkg.sv
// Shared sizing, write-select codes and FSM encoding for the parameter bank loader.
package param_pkg;

    localparam int unsigned NBLK   = 64;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned NBANK  = 3;

    typedef enum logic [1:0] {
        SEL_AMPS    = 2'd0,
        SEL_OFFSETS = 2'd1,
        SEL_PHASE   = 2'd2,
        SEL_RSVD    = 2'd3
    } wr_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ARMED,
        ST_COMMIT
    } state_t;

    function automatic int unsigned bus_width(input int unsigned nblk, input int unsigned word_w);
        return nblk * word_w;
    endfunction

    // Pointer must reach NBLK itself, hence the +1.
    function automatic int unsigned ptr_width(input int unsigned nblk);
        return $clog2(nblk + 1);
    endfunction

endpackage

// File: rtl/param_bank_loader_if.sv
// Word-write and control strobes from the pipe endpoint into the bank loader.
interface param_bank_loader_if #(
    parameter int unsigned WORD_W = param_pkg::WORD_W
);

    logic              wr_en;
    logic [1:0]        wr_sel;
    logic [WORD_W-1:0] wr_data;
    logic              addr_clr;
    logic              swap_req;

    modport master (
        output wr_en,
        output wr_sel,
        output wr_data,
        output addr_clr,
        output swap_req
    );

    modport slave (
        input wr_en,
        input wr_sel,
        input wr_data,
        input addr_clr,
        input swap_req
    );

endinterface

// File: rtl/param_shadow_bank.sv
// One shadow bank: sequential word store with a write pointer that saturates at NBLK.
module param_shadow_bank #(
    parameter int unsigned NBLK   = param_pkg::NBLK,
    parameter int unsigned WORD_W = param_pkg::WORD_W
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic                                          clr,
    input  logic                                          wr,
    input  logic [WORD_W-1:0]                             data,
    output logic [param_pkg::bus_width(NBLK, WORD_W)-1:0] shadow,
    output logic [param_pkg::ptr_width(NBLK)-1:0]         ptr,
    output logic                                          full
);

    import param_pkg::*;

    localparam int unsigned PTR_W = ptr_width(NBLK);

    assign full = (ptr == PTR_W'(NBLK));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow <= '0;
            ptr    <= '0;
        end else begin
            // Decoded word enable keeps every slice select in range.
            if (wr && !full) begin
                for (int unsigned k = 0; k < NBLK; k++) begin
                    if (ptr == PTR_W'(k)) begin
                        shadow[k*WORD_W +: WORD_W] <= data;
                    end
                end
            end
            if (clr) begin
                ptr <= '0;
            end else if (wr && !full) begin
                ptr <= ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/param_bank_loader.sv
// Double-buffered amp/offset/phaseword loader: fills three shadow banks, then commits them
// atomically to the active buses on a swap request.
module param_bank_loader #(
    parameter int unsigned NBLK   = param_pkg::NBLK,
    parameter int unsigned WORD_W = param_pkg::WORD_W
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    param_bank_loader_if.slave                            wr_bus,
    output logic [param_pkg::bus_width(NBLK, WORD_W)-1:0] active_amps,
    output logic [param_pkg::bus_width(NBLK, WORD_W)-1:0] active_offsets,
    output logic [param_pkg::bus_width(NBLK, WORD_W)-1:0] active_phasewords,
    output logic                                          swap_ack,
    output logic                                          armed,
    output logic                                          overflow
);

    import param_pkg::*;

    localparam int unsigned BUS_W = bus_width(NBLK, WORD_W);
    localparam int unsigned PTR_W = ptr_width(NBLK);

    state_t             state;
    state_t             state_nxt;
    logic               pending;

    logic [BUS_W-1:0]   shadow [NBANK];
    logic [PTR_W-1:0]   ptr    [NBANK];
    logic [NBANK-1:0]   bank_full;
    logic [NBANK-1:0]   bank_wr;
    logic               bank_clr;

    logic [NBANK-1:0]   tgt_onehot;
    logic               tgt_full;
    logic [PTR_W-1:0]   tgt_ptr;

    logic               loading;
    logic               commit;
    logic               write_ok;
    logic               accept;
    logic               drop;
    logic               fills;

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        param_shadow_bank #(
            .NBLK   (NBLK),
            .WORD_W (WORD_W)
        ) u_bank (
            .clk     (clk),
            .reset_n (reset_n),
            .clr     (bank_clr),
            .wr      (bank_wr[b]),
            .data    (wr_bus.wr_data),
            .shadow  (shadow[b]),
            .ptr     (ptr[b]),
            .full    (bank_full[b])
        );
    end

    // Reserved select decodes to no bank at all, so it can neither store nor overflow.
    always_comb begin
        tgt_onehot = '0;
        tgt_full   = 1'b0;
        tgt_ptr    = '0;
        for (int unsigned b = 0; b < NBANK; b++) begin
            if (wr_bus.wr_sel == 2'(b)) begin
                tgt_onehot[b] = 1'b1;
                tgt_full      = bank_full[b];
                tgt_ptr       = ptr[b];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE, ST_LOAD: begin
                if (wr_bus.addr_clr) begin
                    state_nxt = ST_IDLE;
                end else if (fills) begin
                    state_nxt = (pending || wr_bus.swap_req) ? ST_COMMIT : ST_ARMED;
                end else if (accept) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_ARMED: begin
                if (wr_bus.addr_clr) begin
                    state_nxt = ST_IDLE;
                end else if (wr_bus.swap_req) begin
                    state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        loading  = (state == ST_IDLE) || (state == ST_LOAD);
        commit   = (state == ST_COMMIT);
        armed    = (state == ST_ARMED);
        write_ok = wr_bus.wr_en && (|tgt_onehot) && !wr_bus.addr_clr;
        accept   = write_ok && loading && !tgt_full;
        drop     = write_ok && (!loading || tgt_full);
        bank_wr  = accept ? tgt_onehot : '0;
        bank_clr = commit || wr_bus.addr_clr;
        fills    = accept && (tgt_ptr == PTR_W'(NBLK - 1))
                   && ((bank_full | tgt_onehot) == '1);
    end

    // A clear arriving during COMMIT still lets this edge copy the shadows out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending           <= 1'b0;
            overflow          <= 1'b0;
            swap_ack          <= 1'b0;
            active_amps       <= '0;
            active_offsets    <= '0;
            active_phasewords <= '0;
        end else begin
            swap_ack <= commit;
            if (commit) begin
                active_amps       <= shadow[0];
                active_offsets    <= shadow[1];
                active_phasewords <= shadow[2];
            end
            if (commit || wr_bus.addr_clr) begin
                pending <= 1'b0;
            end else if (loading && wr_bus.swap_req) begin
                pending <= 1'b1;
            end
            if (wr_bus.addr_clr) begin
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/param_bank_loader.md
PARAM_BANK_LOADER -- requirements
Module: param_bank_loader

Interface
REQ-001 SHALL have parameter NBLK, default 64, number of synthesis blocks per bank.
REQ-002 SHALL have parameter WORD_W, default 16, width of one amp/offset/phaseword value.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port wr_en  input  1  one-cycle word strobe from the pipe endpoint.
REQ-006 SHALL have port wr_sel  input  2  target bank: 0 amps, 1 offsets, 2 phasewords, 3 reserved.
REQ-007 SHALL have port wr_data  input  WORD_W  word written when wr_en=1.
REQ-008 SHALL have port addr_clr  input  1  one-cycle pulse; restarts loading.
REQ-009 SHALL have port swap_req  input  1  one-cycle pulse; requests commit of shadow banks to active banks.
REQ-010 SHALL have ports active_amps, active_offsets, active_phasewords  output  NBLK*WORD_W each  registered parameter buses feeding the synthesis array.
REQ-011 SHALL have port swap_ack  output  1  one-cycle pulse marking the cycle the active buses change.
REQ-012 SHALL have port armed  output  1  high while all three shadow banks hold NBLK words.
REQ-013 SHALL have port overflow  output  1  sticky flag for a dropped write.

Function
REQ-014 SHALL keep a 7-bit write pointer per bank (range 0..NBLK); for each bank, word k SHALL land in bits [k*WORD_W +: WORD_W] of that bank's shadow register.
REQ-015 SHALL, on wr_en with wr_sel in 0..2, pointer < NBLK, and state IDLE or LOAD, store wr_data and increment that pointer.
REQ-016 SHALL drop the word and set overflow when the pointer = NBLK, or when state is ARMED or COMMIT.
REQ-017 SHALL ignore wr_en with wr_sel=3 (no store, no overflow).
REQ-018 SHALL implement the states IDLE (all pointers 0), LOAD, ARMED and COMMIT.
REQ-019 SHALL go IDLE->LOAD on the first accepted write.
REQ-020 SHALL go LOAD->ARMED when all three pointers reach NBLK.
REQ-021 SHALL latch swap_req received in IDLE or LOAD into a pending flag.
REQ-022 SHALL go to COMMIT instead of ARMED when the completing write's cycle has pending set or swap_req=1.
REQ-023 SHALL go ARMED->COMMIT on swap_req.
REQ-024 SHALL spend exactly one cycle in COMMIT, then go to IDLE; on that exit edge it SHALL copy all three shadows to the active buses, pulse swap_ack, clear the pointers and clear pending.
REQ-025 SHALL give a latency of 2 edges from swap_req sampled in ARMED to the active buses updating: the sampling edge enters COMMIT, the next edge updates the buses.
REQ-026 SHALL, on addr_clr, clear the pointers and pending and go to IDLE from any state except COMMIT, retaining shadow contents.
REQ-027 SHALL let addr_clr win over a simultaneous swap_req or wr_en.
REQ-028 SHALL, on addr_clr during COMMIT, complete the commit first and then apply the clear.
REQ-029 SHALL never modify the active buses except at COMMIT exit.
REQ-030 SHALL drive armed high exactly while the state is ARMED.
REQ-031 SHALL clear overflow only by reset or addr_clr.

Reset
REQ-032 SHALL, on reset_n low, immediately zero the shadow and active buses, the pointers, pending, swap_ack and overflow, and set state IDLE.
REQ-033 SHALL cancel any load in progress on reset mid-operation; reset deassertion SHALL cause no swap_ack.

Structure
REQ-034 SHALL take NBLK, WORD_W, bus width, wr_sel codes and the state enum from shared package param_pkg.
REQ-035 SHALL instantiate sub-module param_shadow_bank three times; each instance holds one bank's shadow register and pointer and reports a full flag.

Verification
REQ-036 Load 64 words per bank, with amps word k = k, then pulse swap_req -> armed=1 before the swap; 2 edges later active_amps[15:0]=0 and active_amps[1023:1008]=63; swap_ack=1 for one cycle.
REQ-037 Pulse swap_req after only 10 amp words, then finish loading -> no swap_ack until the last phaseword; COMMIT follows that word; active buses update one edge later.
REQ-038 Send a 65th amp word 16'hBEEF -> overflow=1; active_amps word 63 is not BEEF after the swap.
REQ-039 Send addr_clr and swap_req in the same cycle while in ARMED -> state IDLE, no swap_ack, active buses unchanged, overflow=0.
REQ-040 Drop reset_n during LOAD -> all outputs 0 within the same cycle; no swap_ack after release.
REQ-041 Send wr_sel=3 with wr_en ten times -> pointers stay 0 and overflow stays 0.
